dmem_store_buffer: RTL and testbench

- Decoupling stage directly downstream of the core's data-memory port (DMEM_addr / DMEM_wdata / DMEM_we / fetch_DMEM_addr / DMEM_rdata).
- Queues core stores in a small FIFO and drains them to a variable-latency data memory over a req/ack handshake.
- Forwards buffered store data to core loads.
- Raises stall when full; the stall gates cpu_ena at top level.

---
 rtl/dmem_sb_pkg.sv | 19 +
 rtl/sb_fwd_match.sv | 42 ++++
 rtl/dmem_store_buffer.sv | 140 ++++++++++++++
 tb/tb_dmem_store_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_sb_pkg.sv
// Shared defaults, entry layout and drain FSM states for the data-memory store buffer.
package dmem_sb_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_DW    = 32;
  localparam int unsigned PTR_W    = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE,
    SB_REQ
  } sb_state_e;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding: word-address compare against every buffered entry,
// picking the youngest valid match (the one closest behind the tail pointer).
module sb_fwd_match
  import dmem_sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic [AW-1:0]            addr_i [DEPTH],
  input  logic [DW-1:0]            data_i [DEPTH],
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [$clog2(DEPTH)-1:0] tail_i,
  input  logic [AW-1:0]            fetch_addr_i,
  output logic                     hit_o,
  output logic [DW-1:0]            data_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DEPTH-1:0] match;
  logic [PtrW-1:0]  idx;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = valid_i[i] && (addr_i[i][AW-1:2] == fetch_addr_i[AW-1:2]);
  end

  // Walk from oldest slot (tail-DEPTH) to youngest (tail-1); later hits override.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = int'(DEPTH); k > 0; k--) begin
      idx = tail_i - PtrW'(k);
      if (match[idx]) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between the core data port and a req/ack data memory, with load forwarding.
// Define STORE_BUF_COALESCE_EN to merge a store into the youngest entry on a word-address hit.
module dmem_store_buffer
  import dmem_sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  input  logic [AW-1:0] core_fetch_addr_i,
  output logic [DW-1:0] core_rdata_o,
  output logic          stall_o,
  output logic          empty_o,
  output logic          overflow_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  output logic [AW-1:0] mem_raddr_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d, last_idx;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  sb_state_e        state_q, state_d;
  logic             full, retire, alloc, coalesce;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;

  assign full     = (count_q == FullCnt);
  assign last_idx = tail_q - PtrW'(1);
  assign retire   = (state_q == SB_REQ) && mem_ack_i;

`ifdef STORE_BUF_COALESCE_EN
  // The head entry being offered to memory must not change under an open request.
  assign coalesce = core_we_i && !full && valid_q[last_idx] &&
                    (core_addr_i[AW-1:2] == addr_q[last_idx][AW-1:2]) &&
                    !((state_q == SB_REQ) && (last_idx == head_q));
`else
  assign coalesce = 1'b0;
`endif

  assign alloc = core_we_i && !full && !coalesce;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overflow_d = overflow_q | (core_we_i & full);
    if (retire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PtrW'(1);
    end
    unique case ({alloc, retire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SB_IDLE: if (count_q != '0) state_d = SB_REQ;
      SB_REQ:  if (mem_ack_i) state_d = (count_q != CntW'(1)) ? SB_REQ : SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= SB_IDLE;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      addr_q[tail_q] <= core_addr_i;
      data_q[tail_q] <= core_wdata_i;
    end
    if (coalesce) begin
      data_q[last_idx] <= core_wdata_i;
    end
  end

  sb_fwd_match #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fwd (
    .addr_i      (addr_q),
    .data_i      (data_q),
    .valid_i     (valid_q),
    .tail_i      (tail_q),
    .fetch_addr_i(core_fetch_addr_i),
    .hit_o       (fwd_hit),
    .data_o      (fwd_data)
  );

  assign core_rdata_o = fwd_hit ? fwd_data : mem_rdata_i;
  assign mem_raddr_o  = core_fetch_addr_i;
  assign stall_o      = full;
  assign empty_o      = (count_q == '0) && (state_q == SB_IDLE);
  assign overflow_o   = overflow_q;
  assign mem_req_o    = (state_q == SB_REQ);
  assign mem_addr_o   = addr_q[head_q];
  assign mem_wdata_o  = data_q[head_q];

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed plus random stimulus against a queue-based reference of the store buffer.
module tb_dmem_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0, core_fetch_addr = '0;
  logic [31:0] core_rdata;
  logic        stall, empty, overflow, mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_raddr;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_store_buffer #(
    .DEPTH(DEPTH),
    .AW   (32),
    .DW   (32)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .core_we_i        (core_we),
    .core_addr_i      (core_addr),
    .core_wdata_i     (core_wdata),
    .core_fetch_addr_i(core_fetch_addr),
    .core_rdata_o     (core_rdata),
    .stall_o          (stall),
    .empty_o          (empty),
    .overflow_o       (overflow),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_wdata_o      (mem_wdata),
    .mem_ack_i        (mem_ack),
    .mem_raddr_o      (mem_raddr),
    .mem_rdata_i      (mem_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];     // pending stores, oldest first
  ent_t emit[$];  // writes observed leaving on the memory port
  bit   m_req, m_ovf;
  int   checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd_exp();
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].addr[31:2] == core_fetch_addr[31:2]) return q[i].data;
    return mem_rdata;
  endfunction

  task automatic check_all();
    chk("mem_req", 32'(mem_req), 32'(m_req));
    chk("stall", 32'(stall), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0 && !m_req));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("core_rdata", core_rdata, fwd_exp());
    chk("mem_raddr", mem_raddr, core_fetch_addr);
    if (m_req) begin
      chk("mem_addr", mem_addr, q[0].addr);
      chk("mem_wdata", mem_wdata, q[0].data);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_req = 0;
    m_ovf = 0;
  endtask

  // Advance one clock: compute the reference outcome of this edge, then compare.
  task automatic tick();
    bit   full, coal, nreq;
    ent_t e;
    full = (q.size() == DEPTH);
    coal = 0;
`ifdef STORE_BUF_COALESCE_EN
    if (core_we && !full && q.size() != 0 && q[q.size()-1].addr[31:2] == core_addr[31:2] &&
        !(m_req && q.size() == 1)) coal = 1;
`endif
    if (!m_req) nreq = (q.size() != 0);
    else if (mem_ack) nreq = (q.size() != 1);
    else nreq = 1;
    if (m_req && mem_ack) begin
      e.addr = mem_addr;
      e.data = mem_wdata;
      emit.push_back(e);
    end
    if (core_we && full) m_ovf = 1;
    if (coal) q[q.size()-1].data = core_wdata;
    if (m_req && mem_ack) void'(q.pop_front());
    if (core_we && !full && !coal) begin
      e.addr = core_addr;
      e.data = core_wdata;
      q.push_back(e);
    end
    m_req = nreq;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    core_we    = 1'b1;
    core_addr  = a;
    core_wdata = d;
    tick();
    core_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || m_req) && n < 60) begin
      mem_ack = m_req;
      tick();
      n++;
    end
    mem_ack = 1'b0;
    chk("drain_bound", 32'(n < 60), 32'(1));
  endtask

  initial begin
    model_reset();
    // Reset state
    #12;
    chk("rst_req", 32'(mem_req), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // Single store with a slow ack
    emit.delete();
    push(32'h100, 32'hDEADBEEF);
    chk("lat_p1", 32'(mem_req), 32'(0));
    tick();
    chk("lat_p2", 32'(mem_req), 32'(1));
    tick();
    tick();
    chk("single_addr", mem_addr, 32'h100);
    chk("single_data", mem_wdata, 32'hDEADBEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("single_empty", 32'(empty), 32'(1));
    chk("single_n", 32'(emit.size()), 32'(1));

    // Fill, stall, overflow, then drain in order
    emit.delete();
    for (int i = 1; i <= 5; i++) begin
      push(32'(i) << 4, 32'hA0 + 32'(i));
      if (i == 4) chk("fill_stall", 32'(stall), 32'(1));
    end
    chk("fill_ovf", 32'(overflow), 32'(1));
    drain();
    chk("fill_n", 32'(emit.size()), 32'(4));
    for (int i = 0; i < emit.size() && i < 4; i++) begin
      chk("fill_addr", emit[i].addr, 32'(i + 1) << 4);
      chk("fill_data", emit[i].data, 32'hA1 + 32'(i));
    end

    // Forwarding priority and passthrough
    mem_rdata = 32'hCAFE0000;
    push(32'h200, 32'h11);
    push(32'h200, 32'h22);
    core_fetch_addr = 32'h202;
    #1;
    chk("fwd_young", core_rdata, 32'h22);
    core_fetch_addr = 32'h300;
    #1;
    chk("fwd_pass", core_rdata, 32'hCAFE0000);
    drain();

    // Asynchronous reset in the middle of a request
    push(32'h400, 32'h5);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'(0));
    chk("mid_rst_empty", 32'(empty), 32'(1));
    chk("mid_rst_ovf", 32'(overflow), 32'(0));
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Push and ack in the same cycle at count 2
    emit.delete();
    push(32'h500, 32'h1);
    push(32'h504, 32'h2);
    mem_ack = 1'b1;
    push(32'h508, 32'h3);
    mem_ack = 1'b0;
    chk("simul_head", mem_addr, 32'h504);
    chk("simul_ovf", 32'(overflow), 32'(0));
    drain();
    chk("simul_n", 32'(emit.size()), 32'(3));
    for (int i = 0; i < emit.size() && i < 3; i++)
      chk("simul_order", emit[i].addr, 32'h500 + 32'(4 * i));

    // Repeated store to the youngest entry behind a different head
    emit.delete();
    push(32'h80, 32'h1);
    push(32'h40, 32'hA);
    push(32'h40, 32'hB);
    drain();
`ifdef STORE_BUF_COALESCE_EN
    chk("coal_n", 32'(emit.size()), 32'(2));
    if (emit.size() == 2) chk("coal_data", emit[1].data, 32'hB);
`else
    chk("nocoal_n", 32'(emit.size()), 32'(3));
    if (emit.size() == 3) begin
      chk("nocoal_d1", emit[1].data, 32'hA);
      chk("nocoal_d2", emit[2].data, 32'hB);
    end
`endif

    // Random traffic, including acks outside a request
    for (int i = 0; i < 400; i++) begin
      core_we         = ($urandom % 3) == 0;
      core_addr       = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      core_wdata      = $urandom;
      mem_ack         = ($urandom % 3) == 0;
      core_fetch_addr = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      mem_rdata       = $urandom;
      tick();
    end
    core_we = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
